// File: rtl/alu_pkg.sv
// Shared ALU operation codes and EX/MEM control-field layout for the execute stage.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_NOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;

  // ctrl_mem = {mem_read, mem_write, byte_en, mem_to_reg}
  localparam int CTRL_MEM_W     = 4;
  localparam int MEM_READ_BIT   = 3;
  localparam int MEM_WRITE_BIT  = 2;
  localparam int BYTE_EN_BIT    = 1;
  localparam int MEM_TO_REG_BIT = 0;

endpackage

// File: rtl/ex_mem_alu_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one port.
interface ex_mem_alu_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5
);
  // Handshake: in_valid marks a real instruction in ID/EX; stall acts as the
  // inverse of ready (the upstream stage must hold its slot while stall=1);
  // out_valid marks a real instruction in EX/MEM and qualifies every output.
  logic                  in_valid;
  logic [3:0]            alu_ctrl;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [4:0]            shamt;
  logic                  is_beq;
  logic                  is_bne;
  logic [PC_W-1:0]       pc_plus4;
  logic [DATA_W-1:0]     br_imm;
  logic [REG_W-1:0]      dst_reg;
  logic [DATA_W-1:0]     store_data;
  logic [CTRL_MEM_W-1:0] ctrl_mem;
  logic                  reg_write;
  logic                  stall;
  logic                  flush;

  logic                  out_valid;
  logic [DATA_W-1:0]     alu_result;
  logic                  zero;
  logic                  br_taken;
  logic [PC_W-1:0]       br_target;
  logic                  illegal_op;
  logic [REG_W-1:0]      mem_dst_reg;
  logic [DATA_W-1:0]     mem_store_data;
  logic [CTRL_MEM_W-1:0] mem_ctrl;
  logic                  mem_reg_write;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, shamt, is_beq, is_bne, pc_plus4,
           br_imm, dst_reg, store_data, ctrl_mem, reg_write, stall, flush,
    input  out_valid, alu_result, zero, br_taken, br_target, illegal_op,
           mem_dst_reg, mem_store_data, mem_ctrl, mem_reg_write
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, shamt, is_beq, is_bne, pc_plus4,
           br_imm, dst_reg, store_data, ctrl_mem, reg_write, stall, flush,
    output out_valid, alu_result, zero, br_taken, br_target, illegal_op,
           mem_dst_reg, mem_store_data, mem_ctrl, mem_reg_write
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU; codes outside the defined set yield 0 and flag illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_NOR:  result = ~(op_a | op_b);
      ALU_SLT:  result = DATA_W'($signed(op_a) < $signed(op_b));
      ALU_SLTU: result = DATA_W'(op_a < op_b);
      ALU_SLL:  result = op_b << shamt;
      ALU_SRL:  result = op_b >> shamt;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_alu_stage.sv
// Execute stage: ALU, branch resolution and the EX/MEM pipeline register.
module ex_mem_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5
) (
  input logic               clk,
  input logic               rst,
  ex_mem_alu_stage_if.slave bus
);

  logic [DATA_W-1:0] alu_res;
  logic              alu_ill;
  logic              eq;
  logic              taken;
  logic [PC_W-1:0]   target;
  logic              live;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .alu_ctrl (bus.alu_ctrl),
    .op_a     (bus.op_a),
    .op_b     (bus.op_b),
    .shamt    (bus.shamt),
    .result   (alu_res),
    .illegal  (alu_ill)
  );

  // beq and bne asserted together is malformed decode; neither fires.
  assign eq     = (bus.op_a == bus.op_b);
  assign taken  = bus.in_valid & ((bus.is_beq & ~bus.is_bne & eq) |
                                  (bus.is_bne & ~bus.is_beq & ~eq));
  assign target = bus.pc_plus4 + PC_W'({bus.br_imm[DATA_W-3:0], 2'b00});
  assign live   = bus.in_valid & ~bus.flush;

  logic                  valid_q;
  logic [DATA_W-1:0]     result_q;
  logic                  zero_q;
  logic                  taken_q;
  logic [PC_W-1:0]       target_q;
  logic                  ill_q;
  logic [REG_W-1:0]      dst_q;
  logic [DATA_W-1:0]     sd_q;
  logic [CTRL_MEM_W-1:0] ctrl_q;
  logic                  rw_q;

  // Flush only kills the qualifying/control bits; data fields load anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      ill_q    <= 1'b0;
      dst_q    <= '0;
      sd_q     <= '0;
      ctrl_q   <= '0;
      rw_q     <= 1'b0;
    end else if (!bus.stall) begin
      valid_q  <= live;
      result_q <= alu_res;
      zero_q   <= (alu_res == '0);
      taken_q  <= taken & ~bus.flush;
      target_q <= target;
      ill_q    <= alu_ill & live;
      dst_q    <= bus.dst_reg;
      sd_q     <= bus.store_data;
      ctrl_q   <= live ? bus.ctrl_mem : '0;
      rw_q     <= bus.reg_write & live;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.alu_result     = result_q;
  assign bus.zero           = zero_q;
  assign bus.br_taken       = taken_q;
  assign bus.br_target      = target_q;
  assign bus.illegal_op     = ill_q;
  assign bus.mem_dst_reg    = dst_q;
  assign bus.mem_store_data = sd_q;
  assign bus.mem_ctrl       = ctrl_q;
  assign bus.mem_reg_write  = rw_q;

endmodule

// File: tb/tb_ex_mem_alu_stage.sv
// Bench for ex_mem_alu_stage: reference model feeds an expected queue, checked 1 cycle later.
module tb_ex_mem_alu_stage;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  ex_mem_alu_stage_if #(.DATA_W(32), .PC_W(32), .REG_W(5)) bus ();

  ex_mem_alu_stage #(.DATA_W(32), .PC_W(32), .REG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic        zero;
    logic        taken;
    logic [31:0] target;
    logic        ill;
    logic [4:0]  dst;
    logic [31:0] sd;
    logic [3:0]  ctrl;
    logic        rw;
  } exp_t;

  exp_t exp_q[$];
  exp_t model_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of the value the register will hold after the next edge.
  function automatic exp_t predict(exp_t prev);
    exp_t        e;
    logic [31:0] a, b, r;
    logic        ill, br_ok, valid_now;
    a   = bus.op_a;
    b   = bus.op_b;
    r   = 32'd0;
    ill = 1'b0;
    case (bus.alu_ctrl)
      4'd0: r = a + b;
      4'd1: r = a & b;
      4'd2: r = ~a & ~b;
      4'd3: r = a | b;
      4'd4: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd5: r = {31'd0, a < b};
      4'd6: r = b << bus.shamt;
      4'd7: r = b >> bus.shamt;
      4'd8: r = a + ~b + 32'd1;
      default: ill = 1'b1;
    endcase
    valid_now = bus.in_valid && !bus.flush;
    br_ok = (bus.is_beq && !bus.is_bne && a == b) || (bus.is_bne && !bus.is_beq && a != b);
    if (rst) e = '0;
    else if (bus.stall) e = prev;
    else begin
      e.valid  = valid_now;
      e.res    = r;
      e.zero   = (r == 32'd0);
      e.taken  = valid_now && br_ok;
      e.target = bus.pc_plus4 + (bus.br_imm << 2);
      e.ill    = valid_now && ill;
      e.dst    = bus.dst_reg;
      e.sd     = bus.store_data;
      e.ctrl   = valid_now ? bus.ctrl_mem : 4'd0;
      e.rw     = valid_now && bus.reg_write;
    end
    return e;
  endfunction

  task automatic compare_outputs(input exp_t e);
    check("out_valid",      {31'd0, bus.out_valid},     {31'd0, e.valid});
    check("alu_result",     bus.alu_result,             e.res);
    check("zero",           {31'd0, bus.zero},          {31'd0, e.zero});
    check("br_taken",       {31'd0, bus.br_taken},      {31'd0, e.taken});
    check("br_target",      bus.br_target,              e.target);
    check("illegal_op",     {31'd0, bus.illegal_op},    {31'd0, e.ill});
    check("mem_dst_reg",    {27'd0, bus.mem_dst_reg},   {27'd0, e.dst});
    check("mem_store_data", bus.mem_store_data,         e.sd);
    check("mem_ctrl",       {28'd0, bus.mem_ctrl},      {28'd0, e.ctrl});
    check("mem_reg_write",  {31'd0, bus.mem_reg_write}, {31'd0, e.rw});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    exp_t e;
    e = predict(model_state);
    model_state = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
    else compare_outputs(exp_q.pop_front());
  endtask

  task automatic randomize_inputs();
    bus.in_valid   = 1'($urandom_range(0, 1));
    bus.alu_ctrl   = 4'($urandom_range(0, 15));
    bus.op_a       = $urandom;
    bus.op_b       = ($urandom_range(0, 3) == 0) ? bus.op_a : $urandom;
    bus.shamt      = 5'($urandom_range(0, 31));
    bus.is_beq     = 1'($urandom_range(0, 1));
    bus.is_bne     = 1'($urandom_range(0, 1));
    bus.pc_plus4   = $urandom;
    bus.br_imm     = $urandom;
    bus.dst_reg    = 5'($urandom_range(0, 31));
    bus.store_data = $urandom;
    bus.ctrl_mem   = 4'($urandom_range(0, 15));
    bus.reg_write  = 1'($urandom_range(0, 1));
  endtask

  task automatic set_plain(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = ctrl;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.shamt     = sh;
    bus.is_beq    = 1'b0;
    bus.is_bne    = 1'b0;
    bus.reg_write = 1'b1;
    bus.ctrl_mem  = 4'b0001;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] want);
    set_plain(ctrl, a, b, sh);
    step();
    check(tag, bus.alu_result, want);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_state  = '0;
    rst          = 1'b1;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    randomize_inputs();

    // Reset with random inputs: everything reads 0.
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      step();
      check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_result", bus.alu_result, 32'd0);
    end
    rst = 1'b0;

    // First load lands on the cycle after reset releases.
    run_op("add_wrap", ALU_ADD,  32'h7FFF_FFFF, 32'd1, 5'd0,  32'h8000_0000);
    check("first_load_valid", {31'd0, bus.out_valid}, 32'd1);
    run_op("sub_neg",  ALU_SUB,  32'd5,         32'd7, 5'd0,  32'hFFFF_FFFE);
    run_op("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0,  32'd1);
    run_op("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0,  32'd0);
    run_op("sll",      ALU_SLL,  32'd0,         32'd1, 5'd31, 32'h8000_0000);
    run_op("srl",      ALU_SRL,  32'd0, 32'h8000_0000, 5'd31, 32'd1);
    run_op("nor",      ALU_NOR,  32'd0,         32'd0, 5'd0,  32'hFFFF_FFFF);
    run_op("and",      ALU_AND,  32'hF0F0_1234, 32'hFF00_FF00, 5'd0, 32'hF000_1200);
    run_op("or",       ALU_OR,   32'hF0F0_0000, 32'h0000_00FF, 5'd0, 32'hF0F0_00FF);

    // Branches.
    set_plain(ALU_SUB, 32'd9, 32'd9, 5'd0);
    bus.is_beq   = 1'b1;
    bus.pc_plus4 = 32'h100;
    bus.br_imm   = 32'hFFFF_FFFF;
    step();
    check("beq_taken",  {31'd0, bus.br_taken}, 32'd1);
    check("beq_target", bus.br_target, 32'h0000_00FC);
    check("beq_zero",   {31'd0, bus.zero}, 32'd1);
    bus.is_beq = 1'b0;
    bus.is_bne = 1'b1;
    step();
    check("bne_not_taken", {31'd0, bus.br_taken}, 32'd0);
    bus.is_beq = 1'b1;
    step();
    check("both_br_not_taken", {31'd0, bus.br_taken}, 32'd0);

    // Stall freezes outputs for 3 cycles, with and without flush.
    run_op("pre_stall", ALU_ADD, 32'h1234, 32'd1, 5'd0, 32'h1235);
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      bus.stall = 1'b1;
      bus.flush = 1'b0;
      step();
      check("stall_hold", bus.alu_result, 32'h1235);
    end
    bus.flush = 1'b1;
    step();
    check("stall_flush_hold", {31'd0, bus.out_valid}, 32'd1);

    // Flush alone inserts a bubble.
    set_plain(ALU_SUB, 32'd3, 32'd3, 5'd0);
    bus.is_beq   = 1'b1;
    bus.ctrl_mem = 4'hF;
    bus.flush    = 1'b1;
    step();
    check("flush_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("flush_rw",     {31'd0, bus.mem_reg_write}, 32'd0);
    check("flush_taken",  {31'd0, bus.br_taken}, 32'd0);

    // Illegal code.
    run_op("illegal_result", 4'd12, 32'hDEAD_BEEF, 32'h1, 5'd3, 32'd0);
    check("illegal_flag", {31'd0, bus.illegal_op}, 32'd1);
    set_plain(4'd12, 32'hDEAD_BEEF, 32'h1, 5'd3);
    bus.in_valid = 1'b0;
    step();
    check("illegal_bubble", {31'd0, bus.illegal_op}, 32'd0);

    // Bubble with stale control bits.
    set_plain(ALU_ADD, 32'd1, 32'd2, 5'd0);
    bus.in_valid = 1'b0;
    bus.ctrl_mem = 4'hF;
    step();
    check("bubble_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bubble_rw",    {31'd0, bus.mem_reg_write}, 32'd0);
    check("bubble_ctrl",  {28'd0, bus.mem_ctrl}, 32'd0);

    // Random traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
